mem_lsu: RTL and testbench

Parametrised, word-organised data/instruction memory with byte addressing, RISC-V sub-word access (LB/LH/LW/LBU/LHU, SB/SH/SW), configurable wait states, and a valid/ready request / valid response handshake. It replaces the single-port combinational-read memory in the datapath for multicycle and pipelined cores. The core issues one request at a time and stalls until the response arrives. Misaligned, out-of-range or illegal accesses are reported rather than silently executed.

---
 rtl/mem_lsu_pkg.sv | 29 ++
 rtl/mem_lsu_align.sv | 74 +++++++
 rtl/mem_lsu.sv | 115 +++++++++++
 tb/tb_mem_lsu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_pkg: shared definitions for the mem_lsu load/store memory.
//   - RISC-V funct3 access-size codes
//   - FSM state encodings
//   - byte-lane type and the captured request record
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef logic [1:0] lane_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_lsu_align.sv
// mem_align: combinational sub-word access logic.
//   we, funct3, lane, in_range : access descriptor
//   wdata                      : raw store data from the core
//   rword                      : current contents of the addressed word
//   err                        : illegal funct3, misaligned, or out of range
//   be                         : byte enables to commit (zero on load/error)
//   wdata_lane                 : store data replicated onto the byte lanes
//   rdata                      : extracted and extended load data (zero on store/error)
module mem_align
  import mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  lane_t       lane,
  input  logic        in_range,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        err,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata
);

  logic       legal;
  logic       misal;
  logic [3:0] size_mask;
  logic [3:0] lane_mask;
  logic [31:0] rshift;

  always_comb begin
    legal     = 1'b0;
    misal     = 1'b0;
    size_mask = 4'b0000;
    case (funct3)
      F3_B:  begin legal = 1'b1; size_mask = 4'b0001; end
      F3_H:  begin legal = 1'b1; misal = lane[0]; size_mask = 4'b0011; end
      F3_W:  begin legal = 1'b1; misal = |lane;   size_mask = 4'b1111; end
      // unsigned variants exist only for loads
      F3_BU: begin legal = ~we;  size_mask = 4'b0001; end
      F3_HU: begin legal = ~we;  misal = lane[0]; size_mask = 4'b0011; end
      default: ;
    endcase
  end

  assign err       = ~legal | misal | ~in_range;
  // aligned accesses never shift past bit 3, so truncation is harmless
  assign lane_mask = size_mask << lane;

  // Per byte lane: enable and source byte. Replicating the low byte/half
  // onto every lane lets the enable alone pick the destination.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign be[i] = we & ~err & lane_mask[i];
    assign wdata_lane[VEC_W*i +: VEC_W] =
        (funct3 == F3_W) ? wdata[VEC_W*i       +: VEC_W] :
        (funct3 == F3_H) ? wdata[VEC_W*(i % 2) +: VEC_W] :
                           wdata[7:0];
  end

  assign rshift = rword >> {lane, 3'b000};

  always_comb begin
    rdata = 32'd0;
    case (funct3)
      F3_B:  rdata = {{24{rshift[7]}}, rshift[7:0]};
      F3_BU: rdata = {24'd0, rshift[7:0]};
      F3_H:  rdata = {{16{rshift[15]}}, rshift[15:0]};
      F3_HU: rdata = {16'd0, rshift[15:0]};
      F3_W:  rdata = rword;
      default: ;
    endcase
    if (err || we) rdata = 32'd0;
  end

endmodule

// File: rtl/mem_lsu.sv
module mem_lsu
  import mem_pkg::*;
#(
  parameter int    DEPTH       = 256,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
  end

  logic [1:0]  state;
  logic [3:0]  cnt;
  req_t        req_q;
  req_t        live;
  req_t        cur;
  logic        hs;
  logic        access;
  logic [AW-1:0] idx;
  logic        in_range;
  logic [31:0] rword;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wdata_lane;
  logic [31:0] rdata;

  assign live      = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
  assign req_ready = (state == ST_IDLE) & ~rst;
  assign hs        = (state == ST_IDLE) & req_valid;

  assign access = (WAIT_CYCLES == 0) ? hs : ((state == ST_WAIT) && (cnt == 4'd1));
  assign cur    = (WAIT_CYCLES == 0) ? live : req_q;

  assign idx      = cur.addr[AW+1:2];
  assign in_range = (cur.addr[31:AW+2] == '0);
  assign rword    = mem[idx];

  mem_align u_align (
    .we         (cur.we),
    .funct3     (cur.funct3),
    .lane       (cur.addr[1:0]),
    .in_range   (in_range),
    .wdata      (cur.wdata),
    .rword      (rword),
    .err        (err),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata      (rdata)
  );

  always_ff @(posedge clk) begin
    if (access && !rst) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (be[i]) mem[idx][VEC_W*i +: VEC_W] <= wdata_lane[VEC_W*i +: VEC_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      req_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= access;
      if (access) begin
        rsp_rdata <= rdata;
        rsp_err   <= err;
      end
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q <= live;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              cnt   <= 4'(WAIT_CYCLES);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: instance 0 has no wait states, instance 1
// has three. Requests push their expected response; a negedge monitor pops
// and checks data, error flag and latency whenever rsp_valid is seen.
module tb_mem_lsu;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [31:0] rsp_rdata  [2];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_lsu #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_lsu #(.DEPTH(256), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_rsp: dut%0d got rsp_valid expected none", d);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_dut",   32'(d), 32'(e.dut));
          chk("rsp_rdata", rsp_rdata[d], e.rdata);
          chk("rsp_err",   {31'd0, rsp_err[d]}, {31'd0, e.err});
          chk("rsp_lat",   32'(cyc - e.cyc), (d == 0) ? 32'd1 : 32'd4);
        end
      end
    end
  end

  task automatic wait_ready(input int d);
    int guard = 0;
    while (req_ready[d] !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: dut%0d req_ready stuck low expected 1", d);
    end
  endtask

  task automatic issue(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input bit push,
                       output int hs_cyc);
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    wait_ready(d);
    hs_cyc = cyc;
    if (push) exp_q.push_back('{d, er, ee, cyc});
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = 32'hFFFF_FFFF;
    req_wdata[d] = 32'h5A5A_5A5A;
  endtask

  int h1, h2;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time expired expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 2'b11;
    req_valid = 2'b00;
    req_we = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req_funct3[d] = 3'd0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    chk("ready_in_rst0", {31'd0, req_ready[0]}, 32'd0);
    chk("ready_in_rst1", {31'd0, req_ready[1]}, 32'd0);
    rst = 2'b00;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'd0, req_ready[d]}, 32'd1);
      chk("rst_rvalid", {31'd0, rsp_valid[d]}, 32'd0);
      chk("rst_rdata", rsp_rdata[d], 32'd0);
      chk("rst_err", {31'd0, rsp_err[d]}, 32'd0);
    end

    // ---- no wait states ----
    issue(0, 1, F_W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 1, h1);
    issue(0, 0, F_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 1, h2);
    chk("b2b_spacing_w0", 32'(h2 - h1), 32'd2);
    issue(0, 0, F_B,  32'h13, 32'h0, 32'hFFFFFFDE, 0, 1, h1);
    issue(0, 0, F_BU, 32'h13, 32'h0, 32'h000000DE, 0, 1, h1);
    issue(0, 0, F_H,  32'h12, 32'h0, 32'hFFFFDEAD, 0, 1, h1);
    issue(0, 0, F_HU, 32'h10, 32'h0, 32'h0000BEEF, 0, 1, h1);
    issue(0, 0, F_B,  32'h10, 32'h0, 32'hFFFFFFEF, 0, 1, h1);
    issue(0, 0, F_BU, 32'h11, 32'h0, 32'h000000BE, 0, 1, h1);
    issue(0, 1, F_B,  32'h11, 32'h123456AA, 32'h0, 0, 1, h1);
    issue(0, 1, F_H,  32'h12, 32'hFFFF1234, 32'h0, 0, 1, h1);
    issue(0, 0, F_W,  32'h10, 32'h0, 32'h1234AAEF, 0, 1, h1);
    // error cases
    issue(0, 0, F_W,  32'h02, 32'h0, 32'h0, 1, 1, h1);
    issue(0, 1, F_H,  32'h11, 32'hFFFF, 32'h0, 1, 1, h1);
    issue(0, 0, F_W,  32'h10, 32'h0, 32'h1234AAEF, 0, 1, h1);
    issue(0, 0, F_W,  32'h400, 32'h0, 32'h0, 1, 1, h1);
    issue(0, 1, F_W,  32'h400, 32'h1, 32'h0, 1, 1, h1);
    issue(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, h1);
    issue(0, 1, F_BU, 32'h10, 32'h0, 32'h0, 1, 1, h1);
    issue(0, 0, F_H,  32'h13, 32'h0, 32'h0, 1, 1, h1);
    // last word in range
    issue(0, 1, F_W,  32'h3FC, 32'hCAFEF00D, 32'h0, 0, 1, h1);
    issue(0, 0, F_W,  32'h3FC, 32'h0, 32'hCAFEF00D, 0, 1, h1);
    issue(0, 0, F_HU, 32'h3FE, 32'h0, 32'h0000CAFE, 0, 1, h1);

    // ---- three wait states ----
    issue(1, 1, F_W, 32'h20, 32'h11111111, 32'h0, 0, 1, h1);
    issue(1, 0, F_W, 32'h20, 32'h0, 32'h11111111, 0, 1, h2);
    chk("b2b_spacing_w3", 32'(h2 - h1), 32'd5);

    // valid held through the busy window must yield one transaction
    @(negedge clk);
    wait_ready(1);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = F_B;
    req_addr[1] = 32'h23; req_wdata[1] = 32'h0;
    exp_q.push_back('{1, 32'h00000011, 1'b0, cyc});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_ready_low", {31'd0, req_ready[1]}, 32'd0);
    end
    @(negedge clk);
    chk("ready_after_resp", {31'd0, req_ready[1]}, 32'd1);
    req_valid[1] = 1'b0;

    // reset during WAIT drops the store and its response
    issue(1, 1, F_W, 32'h20, 32'h55, 32'h0, 0, 0, h1);
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, req_ready[1]}, 32'd0);
    chk("midrst_rvalid", {31'd0, rsp_valid[1]}, 32'd0);
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk("midrst_idle", {31'd0, req_ready[1]}, 32'd1);
    repeat (4) @(negedge clk);
    issue(1, 0, F_W, 32'h20, 32'h0, 32'h11111111, 0, 1, h1);

    repeat (10) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
